// File: rtl/iir_cfg_ctrl.sv
// iir_cfg_ctrl: shadow coefficient bank and commit sequencer (drain, load, clear) in front of the opti_top IIR core
module iir_cfg_ctrl #(
    parameter int NUM_SEC   = 4,
    parameter int CW        = 16,
    parameter int DRAIN_MAX = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_wr_en,
    input  logic [4:0]    cfg_addr,
    input  logic [CW-1:0] cfg_wdata,
    input  logic          cfg_commit,
    output logic          cfg_busy,
    output logic          cfg_done,
    output logic          cfg_err,
    input  logic          s_valid_in,
    input  logic [CW-1:0] s_data_in,
    output logic          core_valid_in,
    output logic [CW-1:0] core_data_in,
    input  logic          core_valid_out,
    output logic          coef_we,
    output logic [4:0]    coef_addr,
    output logic [CW-1:0] coef_wdata,
    output logic          core_clr,
    output logic [15:0]   drop_cnt
);
    localparam int NC = NUM_SEC * 5;
    localparam int DW = $clog2(DRAIN_MAX + 1);

    typedef enum logic [1:0] {IDLE, BLOCK, LOAD, CLEAR} state_t;
    state_t state, state_nx;

    logic [CW-1:0] shadow [NC];
    logic [7:0]    inflight;
    logic [DW-1:0] drain;
    logic [4:0]    ld_idx;
    logic idle, drained, drain_end, timeout, wr_ok, wr_err, commit_err, underflow;

    assign idle       = state == IDLE;
    assign drained    = inflight == 8'd0 && !core_valid_in;
    assign drain_end  = drain == DW'(DRAIN_MAX - 1);
    assign timeout    = state == BLOCK && !drained && drain_end;
    assign wr_ok      = cfg_wr_en && idle && cfg_addr < 5'(NC);
    assign wr_err     = cfg_wr_en && !wr_ok;
    assign commit_err = cfg_commit && !idle;
    assign underflow  = core_valid_out && !core_valid_in && inflight == 8'd0;
    assign ld_idx     = state == LOAD ? coef_addr + 5'd1 : 5'd0;
    assign cfg_busy   = !idle;
    assign core_clr   = state == CLEAR;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // next state: drain ends on an empty pipe or on the drain limit; the load walks coef_addr to the last index
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = cfg_commit ? BLOCK : IDLE;
            BLOCK:   state_nx = (drained || drain_end) ? LOAD : BLOCK;
            LOAD:    state_nx = coef_addr == 5'(NC - 1) ? CLEAR : LOAD;
            default: state_nx = IDLE;
        endcase
    end

    // shadow bank: b0 of each section resets to unity, host writes land only while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NC; i++) shadow[i] <= (i % 5 == 0) ? CW'(16'h4000) : '0;
        end else if (wr_ok) begin
            shadow[cfg_addr] <= cfg_wdata;
        end
    end

    // sample path: forward while idle, otherwise zero the stream and count drops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_valid_in <= 1'b0;
            core_data_in  <= '0;
            drop_cnt      <= '0;
        end else begin
            core_valid_in <= idle && s_valid_in;
            core_data_in  <= idle ? s_data_in : '0;
            if (!idle && s_valid_in && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end

    // in-flight tracking and drain timer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
            drain    <= '0;
        end else begin
            drain <= state == BLOCK ? drain + DW'(1) : '0;
            if (state == CLEAR) inflight <= '0;
            else if (core_valid_in && !core_valid_out) inflight <= inflight + 8'd1;
            else if (core_valid_out && !core_valid_in && inflight != 8'd0) inflight <= inflight - 8'd1;
        end
    end

    // coefficient port aligned with the LOAD cycles, plus registered done/error pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coef_we    <= 1'b0;
            coef_addr  <= '0;
            coef_wdata <= '0;
            cfg_done   <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            coef_we    <= state_nx == LOAD;
            coef_addr  <= state_nx == LOAD ? ld_idx : '0;
            coef_wdata <= state_nx == LOAD ? shadow[ld_idx] : '0;
            cfg_done   <= state == CLEAR;
            cfg_err    <= wr_err || commit_err || underflow || timeout;
        end
    end
endmodule

// File: tb/tb_iir_cfg_ctrl.sv
// tb_iir_cfg_ctrl: randomized commit/stream scenarios checked against a timeline model of the sequencer
module tb_iir_cfg_ctrl;
    localparam int NC   = 20;
    localparam int DM   = 64;
    localparam int L    = 3;
    localparam int NCYC = 4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_wr_en = 1'b0;
    logic [4:0]  cfg_addr = '0;
    logic [15:0] cfg_wdata = '0;
    logic        cfg_commit = 1'b0;
    logic        cfg_busy, cfg_done, cfg_err;
    logic        s_valid_in = 1'b0;
    logic [15:0] s_data_in = '0;
    logic        core_valid_in;
    logic [15:0] core_data_in;
    logic        core_valid_out = 1'b0;
    logic        coef_we;
    logic [4:0]  coef_addr;
    logic [15:0] coef_wdata;
    logic        core_clr;
    logic [15:0] drop_cnt;

    int total = 0, bad = 0, cyc = 0, fwd_bad = 0;
    logic [15:0] shadow_m [NC];
    logic [15:0] obs [NC];
    bit          sent_v [NCYC];
    logic [15:0] sent_d [NCYC];
    bit          pipe [$];
    bit          hold = 0, lost = 0;
    int          last_fwd = -1000, busy_lo = -1, busy_hi = -2, drops_m = 0;

    always #5 clk = ~clk;

    iir_cfg_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit),
        .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err),
        .s_valid_in(s_valid_in), .s_data_in(s_data_in),
        .core_valid_in(core_valid_in), .core_data_in(core_data_in), .core_valid_out(core_valid_out),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .core_clr(core_clr), .drop_cnt(drop_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic bit idle_at(input int c);
        return !(c >= busy_lo && c <= busy_hi);
    endfunction

    function automatic void bank_defaults();
        for (int i = 0; i < NC; i++) shadow_m[i] = (i % 5 == 0) ? 16'h4000 : 16'h0000;
    endfunction

    // one clock: verify last cycle's forwarding, emulate a latency-L core, clear strobes
    task automatic tick();
        bit r0, ev;
        r0 = rst_n;
        @(posedge clk);
        #1;
        cyc++;
        if (r0 && rst_n && cyc < NCYC) begin
            ev = sent_v[cyc-1] && idle_at(cyc-1);
            if (core_valid_in !== ev || core_data_in !== (idle_at(cyc-1) ? sent_d[cyc-1] : 16'h0)) fwd_bad++;
        end
        pipe.push_back(core_valid_in);
        core_valid_out = 1'b0;
        if (pipe.size() > L) core_valid_out = pipe.pop_front() && !hold;
        cfg_commit = 1'b0; cfg_wr_en = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        s_valid_in = 1'b0; s_data_in = '0;
        if (cyc < NCYC) begin sent_v[cyc] = 1'b0; sent_d[cyc] = '0; end
    endtask

    task automatic drive_sample(input int dens);
        s_valid_in = dens == 2 ? 1'b1 : dens == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
        s_data_in  = 16'($urandom);
        if (cyc < NCYC) begin sent_v[cyc] = s_valid_in; sent_d[cyc] = s_data_in; end
        if (s_valid_in) begin
            if (idle_at(cyc)) begin last_fwd = cyc; lost |= hold; end
            else if (drops_m < 65535) drops_m++;
        end
    endtask

    task automatic idle(input int n, input int dens);
        repeat (n) begin drive_sample(dens); tick(); end
    endtask

    task automatic wr(input logic [4:0] a, input logic [15:0] d);
        cfg_wr_en = 1'b1; cfg_addr = a; cfg_wdata = d;
        if (a < NC) shadow_m[a] = d;
        tick();
        check("wr_err", cfg_err, a >= NC);
    endtask

    task automatic commit_seq(input string tag, input int dens, input bit with_wr, input bit collide, input bit rst_mid);
        int t0, ls, n_we, n_bad, we_first, clr_n, clr_c, done_n, done_c, busy_n, busy_first, busy_last, a;
        bit to;
        logic [15:0] bank [NC];
        int errs[$], exp_errs[$];
        t0 = cyc;
        cfg_commit = 1'b1;
        if (with_wr) begin
            a = $urandom_range(0, NC - 1);
            cfg_wr_en = 1'b1; cfg_addr = 5'(a); cfg_wdata = 16'($urandom);
            shadow_m[a] = cfg_wdata;
        end
        drive_sample(dens);
        ls = (last_fwd + L + 3 > t0 + 2) ? last_fwd + L + 3 : t0 + 2;
        to = lost || ls > t0 + DM + 1;
        if (to) ls = t0 + DM + 1;
        busy_lo = t0 + 1;
        busy_hi = ls + NC;
        bank = shadow_m;
        if (to) exp_errs.push_back(ls);
        if (collide) begin exp_errs.push_back(ls + 4); exp_errs.push_back(ls + 9); end
        n_we = 0; n_bad = 0; we_first = -1; clr_n = 0; clr_c = -1; done_n = 0; done_c = -1;
        busy_n = 0; busy_first = -1; busy_last = -1;
        while (1) begin
            tick();
            if (coef_we) begin
                if (n_we == 0) we_first = cyc;
                if (n_we < NC) begin
                    if (coef_addr !== 5'(n_we) || coef_wdata !== bank[n_we]) n_bad++;
                    obs[n_we] = coef_wdata;
                end
                n_we++;
            end
            if (core_clr) begin clr_n++; clr_c = cyc; end
            if (cfg_done) begin done_n++; done_c = cyc; end
            if (cfg_err) errs.push_back(cyc);
            if (cfg_busy) begin busy_n++; busy_last = cyc; if (busy_first < 0) busy_first = cyc; end
            if (rst_mid && cyc == ls + 10) begin
                check({tag, "_idx"}, coef_addr, 10);
                #1 rst_n = 1'b0;
                #1;
                check({tag, "_rst_we"}, coef_we, 0);
                check({tag, "_rst_addr"}, coef_addr, 0);
                check({tag, "_rst_wdata"}, coef_wdata, 0);
                check({tag, "_rst_busy"}, cfg_busy, 0);
                check({tag, "_rst_drop"}, drop_cnt, 0);
                check({tag, "_rst_clr"}, core_clr, 0);
                bank_defaults();
                pipe.delete();
                core_valid_out = 1'b0;
                last_fwd = -1000; lost = 0; drops_m = 0; busy_hi = cyc;
                return;
            end
            if (cyc >= ls + NC + 3) break;
            if (collide && cyc == ls + 3) cfg_commit = 1'b1;
            if (collide && cyc == ls + 8) begin cfg_wr_en = 1'b1; cfg_addr = 5'(NC - 1); cfg_wdata = ~shadow_m[NC-1]; end
            drive_sample(dens);
        end
        check({tag, "_we_n"}, n_we, NC);
        check({tag, "_we_first"}, we_first, ls);
        check({tag, "_bank"}, n_bad, 0);
        check({tag, "_clr_n"}, clr_n, 1);
        check({tag, "_clr_at"}, clr_c, ls + NC);
        check({tag, "_done_n"}, done_n, 1);
        check({tag, "_done_at"}, done_c, ls + NC + 1);
        check({tag, "_busy_first"}, busy_first, t0 + 1);
        check({tag, "_busy_last"}, busy_last, ls + NC);
        check({tag, "_busy_n"}, busy_n, ls + NC - t0);
        check({tag, "_err_n"}, errs.size(), exp_errs.size());
        for (int i = 0; i < errs.size() && i < exp_errs.size(); i++) check({tag, "_err_at"}, errs[i], exp_errs[i]);
        check({tag, "_drop"}, drop_cnt, drops_m);
        check({tag, "_fwd"}, fwd_bad, 0);
        lost = 0;
    endtask

    initial begin
        bank_defaults();
        repeat (3) tick();
        rst_n = 1'b1;
        check("rst_busy", cfg_busy, 0);
        check("rst_done", cfg_done, 0);
        check("rst_err", cfg_err, 0);
        check("rst_we", coef_we, 0);
        check("rst_clr", core_clr, 0);
        check("rst_valid", core_valid_in, 0);
        check("rst_drop", drop_cnt, 0);
        idle(3, 0);
        commit_seq("defaults", 0, 0, 0, 0);
        check("def_b0_s1", obs[5], 16'h4000);
        check("def_b1_s0", obs[1], 16'h0000);
        wr(5'd7, 16'h1234);
        wr(5'd20, 16'hBEEF);
        idle(2, 1);
        commit_seq("addr7", 1, 0, 0, 0);
        check("addr7_data", obs[7], 16'h1234);
        idle(8, 2);
        commit_seq("drain", 2, 1, 0, 0);
        hold = 1'b1;
        idle(2, 2);
        idle(2, 0);
        commit_seq("timeout", 0, 0, 0, 0);
        hold = 1'b0;
        idle(2, 0);
        core_valid_out = 1'b1;
        tick();
        check("underflow_err", cfg_err, 1);
        tick();
        check("err_pulse", cfg_err, 0);
        commit_seq("collide", 1, 0, 1, 0);
        commit_seq("rstmid", 1, 0, 0, 1);
        idle(2, 0);
        rst_n = 1'b1;
        idle(2, 1);
        commit_seq("reload", 1, 0, 0, 0);
        check("reload_b0", obs[0], 16'h4000);
        check("reload_a7", obs[7], 16'h0000);
        for (int r = 0; r < 4; r++) begin
            repeat ($urandom_range(1, 4)) wr(5'($urandom_range(0, NC - 1)), 16'($urandom));
            idle($urandom_range(1, 8), $urandom_range(0, 2));
            commit_seq("rand", $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0, 0);
        end
        check("fwd_total", fwd_bad, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
